// File: rtl/digitizer_pkg.sv
// Shared types and constants for the ADC stream packetizer.
// Packet header insertion is controlled by the ADC_PKT_HEADER_EN macro.
package digitizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pkt_state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA5A5;
    localparam int          SAMPLE_W  = 16;

endpackage

// File: rtl/adc_pkt_fifo.sv
// First-word-fall-through FIFO holding {last, data}; depth 2**AW.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module adc_pkt_fifo #(
    parameter int AW = 4,
    parameter int W  = 33
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok, rd_ok;

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_ok     = rd_en_i && !empty_o;
    assign wr_ok     = wr_en_i && ((count_q != DEPTH) || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/adc_stream_packetizer.sv
// Packs 16-bit ADC samples into 32-bit AXI4-Stream words, framed into fixed-length packets.
// Define ADC_PKT_HEADER_EN to prefix every packet with a {A5A5, seq} header word.
module adc_stream_packetizer
    import digitizer_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int PKT_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                ctrl_start,
    input  logic                ctrl_test,
    input  logic [PKT_W-1:0]    ctrl_pkt_size,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                overflow
);

    localparam logic [PKT_W-1:0]   PKT_ONE = PKT_W'(1);
    localparam logic [FIFO_AW:0]   DEPTH   = (FIFO_AW+1)'(2**FIFO_AW);

    pkt_state_t            state_q, state_d;
    logic [PKT_W-1:0]      pkt_size_q, pkt_size_d;
    logic [PKT_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  half_q, half_d;
    logic [SAMPLE_W-1:0]   half_data_q, half_data_d;
    logic [SAMPLE_W-1:0]   test_cnt_q, test_cnt_d;
    logic                  pend_q, pend_d;
    logic [31:0]           pend_data_q, pend_data_d;
    logic                  overflow_q, overflow_d;
`ifdef ADC_PKT_HEADER_EN
    logic [15:0]           seq_q, seq_d;
    logic                  hdr_sent_q, hdr_sent_d;
    logic                  fifo_room2;
`endif

    logic                  fifo_wr, fifo_rd, fifo_empty, fifo_full, fifo_room1;
    logic [32:0]           fifo_wdata, fifo_rdata;
    logic [FIFO_AW:0]      fifo_count;
    logic [SAMPLE_W-1:0]   sample;
    logic                  pend_last, leave_run;

    adc_pkt_fifo #(
        .AW (FIFO_AW),
        .W  (33)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 32'd0 : fifo_rdata[31:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0  : fifo_rdata[32];
    assign busy          = (state_q != IDLE);
    assign overflow      = overflow_q;

    assign fifo_rd    = m_axis_tvalid && m_axis_tready;
    assign fifo_full  = (fifo_count == DEPTH);
    assign fifo_room1 = !fifo_full || fifo_rd;
`ifdef ADC_PKT_HEADER_EN
    assign fifo_room2 = (fifo_count <= DEPTH - 2) || (fifo_rd && (fifo_count <= DEPTH - 1));
`endif

    assign sample    = ctrl_test ? test_cnt_q : adc_data;
    assign pend_last = (word_cnt_q == pkt_size_q - PKT_ONE);
    // Leave RUN only on a packet boundary with nothing half-built or waiting to be written.
    assign leave_run = !ctrl_start && (word_cnt_q == '0) && !half_q && !pend_q;

    always_comb begin
        state_d     = state_q;
        pkt_size_d  = pkt_size_q;
        word_cnt_d  = word_cnt_q;
        half_d      = half_q;
        half_data_d = half_data_q;
        test_cnt_d  = test_cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        overflow_d  = overflow_q;
`ifdef ADC_PKT_HEADER_EN
        seq_d       = seq_q;
        hdr_sent_d  = hdr_sent_q;
`endif
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;

        // Write stage: completed word goes to the FIFO, or is dropped without advancing the packet.
        if (pend_q) begin
`ifdef ADC_PKT_HEADER_EN
            if ((word_cnt_q == '0) && !hdr_sent_q) begin
                if (fifo_room2) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = {1'b0, HDR_MAGIC, seq_q};
                    hdr_sent_d = 1'b1;
                end else begin
                    pend_d     = 1'b0;
                    overflow_d = 1'b1;
                end
            end else
`endif
            begin
                if (fifo_room1) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = {pend_last, pend_data_q};
                    pend_d     = 1'b0;
                    if (pend_last) begin
                        word_cnt_d = '0;
`ifdef ADC_PKT_HEADER_EN
                        hdr_sent_d = 1'b0;
                        seq_d      = seq_q + 16'd1;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + PKT_ONE;
                    end
                end else begin
                    pend_d     = 1'b0;
                    overflow_d = 1'b1;
                end
            end
        end

        if ((state_q == RUN) && !leave_run && adc_valid) begin
            test_cnt_d = test_cnt_q + 16'd1;
            if (!half_q) begin
                half_d      = 1'b1;
                half_data_d = sample;
            end else begin
                half_d      = 1'b0;
                pend_d      = 1'b1;
                pend_data_d = {sample, half_data_q};
            end
        end

        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    state_d    = RUN;
                    pkt_size_d = (ctrl_pkt_size == '0) ? PKT_ONE : ctrl_pkt_size;
                    word_cnt_d = '0;
                    half_d     = 1'b0;
                    test_cnt_d = '0;
                    overflow_d = 1'b0;
`ifdef ADC_PKT_HEADER_EN
                    seq_d      = '0;
                    hdr_sent_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (leave_run) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !pend_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pkt_size_q <= PKT_ONE;
            word_cnt_q <= '0;
            half_q     <= 1'b0;
            test_cnt_q <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ADC_PKT_HEADER_EN
            seq_q      <= '0;
            hdr_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pkt_size_q <= pkt_size_d;
            word_cnt_q <= word_cnt_d;
            half_q     <= half_d;
            test_cnt_q <= test_cnt_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
`ifdef ADC_PKT_HEADER_EN
            seq_q      <= seq_d;
            hdr_sent_q <= hdr_sent_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        half_data_q <= half_data_d;
        pend_data_q <= pend_data_d;
    end

endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Scoreboard bench for adc_stream_packetizer: expected stream words are queued by the
// stimulus and compared by an independent monitor on every AXIS transfer.
module tb_adc_stream_packetizer;

    localparam int FIFO_AW = 4;
    localparam int PKT_W   = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             adc_valid;
    logic [15:0]      adc_data;
    logic             ctrl_start;
    logic             ctrl_test;
    logic [PKT_W-1:0] ctrl_pkt_size;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             busy;
    logic             overflow;

    logic [32:0]      sb_q [$];
    logic [32:0]      exp_w;
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    adc_stream_packetizer #(
        .FIFO_AW (FIFO_AW),
        .PKT_W   (PKT_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .ctrl_start    (ctrl_start),
        .ctrl_test     (ctrl_test),
        .ctrl_pkt_size (ctrl_pkt_size),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .overflow      (overflow)
    );

    always @(negedge clk) begin
        if (resetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra: got data %h last %b, expected no transfer",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                exp_w = sb_q.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== exp_w) begin
                    n_err++;
                    $display("FAIL stream_word: got data %h last %b, expected data %h last %b",
                             m_axis_tdata, m_axis_tlast, exp_w[31:0], exp_w[32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Test-counter words: word n is {2n+1, 2n}; TLAST on the last word of each packet.
    task automatic push_words(input int first, input int cnt, input int pkt);
        for (int n = first; n < first + cnt; n++) begin
            sb_q.push_back({((n % pkt) == pkt - 1), 16'(2 * n + 1), 16'(2 * n)});
        end
    endtask

    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'hDEAD;
            tick();
            adc_valid = 1'b0;
            for (int g = 1; g < gap; g++) tick();
        end
    endtask

    task automatic send_data(input logic [15:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check(name, sb_q.size(), 32'd0);
    endtask

    task automatic start_run(input logic [PKT_W-1:0] pkt, input logic test);
        ctrl_start = 1'b0;
        wait_idle("idle_before_start");
        ctrl_pkt_size = pkt;
        ctrl_test     = test;
        ctrl_start    = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        resetn        = 1'b0;
        adc_valid     = 1'b0;
        adc_data      = '0;
        ctrl_start    = 1'b0;
        ctrl_test     = 1'b0;
        ctrl_pkt_size = '0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        check("rst_tvalid",   {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast",    {31'd0, m_axis_tlast},  32'd0);
        check("rst_tdata",    m_axis_tdata,           32'd0);
        check("rst_busy",     {31'd0, busy},          32'd0);
        check("rst_overflow", {31'd0, overflow},      32'd0);
        resetn = 1'b1;
        tick();

`ifdef ADC_PKT_HEADER_EN
        // Header words precede each 4-word packet.
        start_run(16'd4, 1'b1);
        sb_q.push_back({1'b0, 32'hA5A5_0000});
        push_words(0, 4, 4);
        sb_q.push_back({1'b0, 32'hA5A5_0001});
        push_words(4, 4, 4);
        send(16, 1);
        wait_drain("hdr_drain");
`else
        // 32-word packets, samples every 10 clocks; second packet starts at 0x0041_0040.
        start_run(16'd32, 1'b1);
        push_words(0, 64, 32);
        send(128, 10);
        wait_drain("t1_drain");

        // Packet size 0 behaves as single-word packets.
        start_run(16'd0, 1'b1);
        push_words(0, 3, 1);
        send(6, 2);
        wait_drain("t2_drain");
        check("t2_overflow", {31'd0, overflow}, 32'd0);

        // Backpressure: 16 words fit, the rest are dropped and flagged.
        start_run(16'd4, 1'b1);
        m_axis_tready = 1'b0;
        push_words(0, 16, 4);
        send(32, 1);
        tick(); tick(); tick();
        check("t3_ovf_before", {31'd0, overflow},      32'd0);
        check("t3_tvalid",     {31'd0, m_axis_tvalid}, 32'd1);
        send(8, 1);
        tick(); tick(); tick();
        check("t3_ovf_after",  {31'd0, overflow},      32'd1);
        check("t3_head_hold",  m_axis_tdata,           32'h0001_0000);
        m_axis_tready = 1'b1;
        wait_drain("t3_drain");
        tick();
        check("t3_empty", {31'd0, m_axis_tvalid}, 32'd0);

        // Reset mid-packet discards everything.
        m_axis_tready = 1'b0;
        send(3, 1);
        tick(); tick();
        check("t5_pre_valid", {31'd0, m_axis_tvalid}, 32'd1);
        resetn = 1'b0;
        tick();
        check("t5_tvalid",   {31'd0, m_axis_tvalid}, 32'd0);
        check("t5_busy",     {31'd0, busy},          32'd0);
        check("t5_overflow", {31'd0, overflow},      32'd0);
        check("t5_tlast",    {31'd0, m_axis_tlast},  32'd0);
        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        start_run(16'd4, 1'b1);
        push_words(0, 4, 4);
        send(8, 2);
        wait_drain("t5_drain");

        // Stop after word 5: the packet still completes with 32 words.
        start_run(16'd32, 1'b1);
        push_words(0, 32, 32);
        for (int i = 0; i < 64; i++) begin
            if (i == 10) ctrl_start = 1'b0;
            adc_valid = 1'b1;
            tick();
            adc_valid = 1'b0;
            tick();
        end
        wait_drain("t4_drain");
        wait_idle("t4_idle");
        start_run(16'd8, 1'b1);
        push_words(0, 8, 8);
        send(16, 2);
        wait_drain("t4_restart_drain");

        // Live ADC data path.
        start_run(16'd2, 1'b0);
        sb_q.push_back({1'b0, 32'h2222_1111});
        sb_q.push_back({1'b1, 32'h4444_3333});
        send_data(16'h1111);
        send_data(16'h2222);
        send_data(16'h3333);
        send_data(16'h4444);
        wait_drain("live_drain");
        check("final_overflow", {31'd0, overflow}, 32'd0);
`endif

        ctrl_start = 1'b0;
        wait_idle("final_idle");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
